// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, FSM state types
// and the byte-strobe merge helper used by register banks.
package axi4_lite_pkg;

    typedef logic [1:0] axil_resp_t;

    localparam axil_resp_t RESP_OKAY   = 2'b00;
    localparam axil_resp_t RESP_EXOKAY = 2'b01;
    localparam axil_resp_t RESP_SLVERR = 2'b10;
    localparam axil_resp_t RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE,
        W_PART,
        W_RESP
    } axil_wstate_e;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } axil_rstate_e;

    function automatic logic [31:0] apply_wstrb(
        input logic [31:0] old,
        input logic [31:0] data,
        input logic [3:0]  strb
    );
        logic [31:0] res;
        res = old;
        for (int k = 0; k < 4; k++) begin
            if (strb[k]) begin
                res[8*k +: 8] = data[8*k +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-Lite bundle with master and slave views.
interface axi4_lite_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    awvalid;
    logic                    awready;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    wvalid;
    logic                    wready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    bvalid;
    logic                    bready;
    logic [1:0]              bresp;
    logic                    arvalid;
    logic                    arready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    rvalid;
    logic                    rready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        output arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        input  arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axi4_lite_reg_slave.sv
// AXI4-Lite slave terminating in a bank of RW and RO registers,
// one outstanding write and one outstanding read.
module axi4_lite_reg_slave
    import axi4_lite_pkg::*;
#(
    parameter int DATA_BYTE_WIDTH = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int NUM_RW          = 16,
    parameter int NUM_RO          = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    axi4_lite_if.slave                 s_axil,
    output logic [NUM_RW*32-1:0]       rw_q,
    output logic [NUM_RW-1:0]          rw_wr_pulse,
    input  logic [NUM_RO*32-1:0]       ro_d,
    output logic [NUM_RW+NUM_RO-1:0]   rd_pulse
);

    localparam int DW = 8 * DATA_BYTE_WIDTH;
    localparam int IW = ADDR_WIDTH - 2;
    localparam int NR = NUM_RW + NUM_RO;

    axil_wstate_e w_state_q, w_state_d;
    logic         aw_held_q, aw_held_d;
    logic         w_held_q, w_held_d;
    logic [IW-1:0]              awidx_q, awidx_d;
    logic [DW-1:0]              wdata_q, wdata_d;
    logic [DATA_BYTE_WIDTH-1:0] wstrb_q, wstrb_d;
    axil_resp_t                 bresp_q, bresp_d;
    logic [NUM_RW-1:0][DW-1:0]  regs_q, regs_d;
    logic [NUM_RW-1:0]          wr_pulse_q, wr_pulse_d;

    axil_rstate_e r_state_q, r_state_d;
    logic [DW-1:0]  rdata_q, rdata_d;
    axil_resp_t     rresp_q, rresp_d;
    logic [NR-1:0]  rd_pulse_q, rd_pulse_d;

    logic [NUM_RO-1:0][DW-1:0] ro_w;
    logic [IW-1:0]             ar_idx;
    logic [DW-1:0]             rd_data_n;
    axil_resp_t                rd_resp_n;
    logic [NR-1:0]             rd_hit_n;
    logic                      wr_hit;
    logic                      aw_hs, w_hs;
    logic                      unused_ok;

    assign ro_w   = ro_d;
    assign ar_idx = s_axil.araddr[ADDR_WIDTH-1:2];

    assign unused_ok = ^{s_axil.awprot, s_axil.arprot,
                         s_axil.awaddr[1:0], s_axil.araddr[1:0]};

    // Readies come only from registered state, never from a valid.
    assign s_axil.awready = !aw_held_q && (w_state_q != W_RESP);
    assign s_axil.wready  = !w_held_q && (w_state_q != W_RESP);
    assign s_axil.bvalid  = (w_state_q == W_RESP);
    assign s_axil.bresp   = bresp_q;
    assign s_axil.arready = (r_state_q == R_IDLE);
    assign s_axil.rvalid  = (r_state_q == R_RESP);
    assign s_axil.rdata   = rdata_q;
    assign s_axil.rresp   = rresp_q;

    assign rw_q        = regs_q;
    assign rw_wr_pulse = wr_pulse_q;
    assign rd_pulse    = rd_pulse_q;

    assign aw_hs = s_axil.awvalid && s_axil.awready;
    assign w_hs  = s_axil.wvalid && s_axil.wready;

    always_comb begin
        w_state_d  = w_state_q;
        aw_held_d  = aw_held_q;
        w_held_d   = w_held_q;
        awidx_d    = awidx_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bresp_d    = bresp_q;
        regs_d     = regs_q;
        wr_pulse_d = '0;
        wr_hit     = 1'b0;
        unique case (w_state_q)
            W_IDLE, W_PART: begin
                if (aw_held_q && w_held_q) begin
                    for (int i = 0; i < NUM_RW; i++) begin
                        if (awidx_q == IW'(i)) begin
                            regs_d[i] = apply_wstrb(regs_q[i], wdata_q, wstrb_q);
                            wr_pulse_d[i] = 1'b1;
                            wr_hit = 1'b1;
                        end
                    end
                    bresp_d   = wr_hit ? RESP_OKAY : RESP_SLVERR;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    w_state_d = W_RESP;
                end else begin
                    if (aw_hs) begin
                        aw_held_d = 1'b1;
                        awidx_d   = s_axil.awaddr[ADDR_WIDTH-1:2];
                    end
                    if (w_hs) begin
                        w_held_d = 1'b1;
                        wdata_d  = s_axil.wdata;
                        wstrb_d  = s_axil.wstrb;
                    end
                    w_state_d = (aw_held_d || w_held_d) ? W_PART : W_IDLE;
                end
            end
            W_RESP: begin
                if (s_axil.bready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Read decode uses pre-commit register contents, so a read that
    // lands on a commit edge returns the old value.
    always_comb begin
        rd_data_n = '0;
        rd_resp_n = RESP_SLVERR;
        rd_hit_n  = '0;
        for (int i = 0; i < NUM_RW; i++) begin
            if (ar_idx == IW'(i)) begin
                rd_data_n   = regs_q[i];
                rd_resp_n   = RESP_OKAY;
                rd_hit_n[i] = 1'b1;
            end
        end
        for (int j = 0; j < NUM_RO; j++) begin
            if (ar_idx == IW'(NUM_RW + j)) begin
                rd_data_n            = ro_w[j];
                rd_resp_n            = RESP_OKAY;
                rd_hit_n[NUM_RW + j] = 1'b1;
            end
        end
    end

    always_comb begin
        r_state_d  = r_state_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        rd_pulse_d = '0;
        unique case (r_state_q)
            R_IDLE: begin
                if (s_axil.arvalid) begin
                    rdata_d    = rd_data_n;
                    rresp_d    = rd_resp_n;
                    rd_pulse_d = rd_hit_n;
                    r_state_d  = R_RESP;
                end
            end
            R_RESP: begin
                if (s_axil.rready) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_state_q  <= W_IDLE;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awidx_q    <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bresp_q    <= RESP_OKAY;
            regs_q     <= '0;
            wr_pulse_q <= '0;
            r_state_q  <= R_IDLE;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
            rd_pulse_q <= '0;
        end else begin
            w_state_q  <= w_state_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            awidx_q    <= awidx_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bresp_q    <= bresp_d;
            regs_q     <= regs_d;
            wr_pulse_q <= wr_pulse_d;
            r_state_q  <= r_state_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            rd_pulse_q <= rd_pulse_d;
        end
    end

endmodule

// File: tb/tb_axi4_lite_reg_slave.sv
// Directed bench for axi4_lite_reg_slave: vector table plus
// hand-written timing sequences.
module tb_axi4_lite_reg_slave;

    localparam int NUM_RW = 16;
    localparam int NUM_RO = 16;

    typedef struct {
        logic        is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } vec_t;

    logic clk;
    logic rst_n;
    logic [NUM_RW*32-1:0]      rw_q;
    logic [NUM_RW-1:0]         rw_wr_pulse;
    logic [NUM_RO*32-1:0]      ro_d;
    logic [NUM_RW+NUM_RO-1:0]  rd_pulse;

    int checks = 0;
    int errors = 0;

    vec_t        vecs [0:13];
    logic [31:0] model [0:15];

    axi4_lite_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    axi4_lite_reg_slave #(
        .DATA_BYTE_WIDTH(4),
        .ADDR_WIDTH(32),
        .NUM_RW(NUM_RW),
        .NUM_RO(NUM_RO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .s_axil(bus),
        .rw_q(rw_q),
        .rw_wr_pulse(rw_wr_pulse),
        .ro_d(ro_d),
        .rd_pulse(rd_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rw_word(input int i);
        return rw_q[32*i +: 32];
    endfunction

    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic [1:0] r);
        int   n;
        logic aw_p, w_p;
        aw_p = 1'b1;
        w_p  = 1'b1;
        n    = 0;
        bus.awaddr  = a;
        bus.wdata   = d;
        bus.wstrb   = s;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        while ((aw_p || w_p) && n < 20) begin
            if (bus.awvalid && bus.awready) aw_p = 1'b0;
            if (bus.wvalid && bus.wready) w_p = 1'b0;
            tick();
            n++;
            if (!aw_p) bus.awvalid = 1'b0;
            if (!w_p) bus.wvalid = 1'b0;
        end
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        n = 0;
        while (!bus.bvalid && n < 20) begin
            tick();
            n++;
        end
        check("wr_bvalid", 64'(bus.bvalid), 64'd1);
        r = bus.bresp;
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d,
                           output logic [1:0] r);
        int n;
        n = 0;
        bus.araddr  = a;
        bus.arvalid = 1'b1;
        while (!bus.arready && n < 20) begin
            tick();
            n++;
        end
        tick();
        bus.arvalid = 1'b0;
        check("rd_rvalid", 64'(bus.rvalid), 64'd1);
        d = bus.rdata;
        r = bus.rresp;
        bus.rready = 1'b1;
        tick();
        bus.rready = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        int          idx;

        bus.awvalid = 0; bus.awaddr = 0; bus.awprot = 0;
        bus.wvalid  = 0; bus.wdata  = 0; bus.wstrb  = 0;
        bus.bready  = 0;
        bus.arvalid = 0; bus.araddr = 0; bus.arprot = 0;
        bus.rready  = 0;
        for (int j = 0; j < NUM_RO; j++) ro_d[32*j +: 32] = 32'h5A00_0000 + j;
        ro_d[31:0]  = 32'h0BAD_0001;
        ro_d[63:32] = 32'hCAFE_F00D;
        for (int i = 0; i < 16; i++) model[i] = '0;

        vecs[0]  = '{1'b1, 32'h00, 32'hA5A5_1234, 4'hF, 2'b00, 32'h0};
        vecs[1]  = '{1'b0, 32'h00, 32'h0,         4'h0, 2'b00, 32'hA5A5_1234};
        vecs[2]  = '{1'b1, 32'h04, 32'h1122_3344, 4'hF, 2'b00, 32'h0};
        vecs[3]  = '{1'b1, 32'h3C, 32'hDEAD_BEEF, 4'hC, 2'b00, 32'h0};
        vecs[4]  = '{1'b0, 32'h3C, 32'h0,         4'h0, 2'b00, 32'hDEAD_0000};
        vecs[5]  = '{1'b1, 32'h40, 32'h1234_5678, 4'hF, 2'b10, 32'h0};
        vecs[6]  = '{1'b0, 32'h44, 32'h0,         4'h0, 2'b00, 32'hCAFE_F00D};
        vecs[7]  = '{1'b0, 32'h40, 32'h0,         4'h0, 2'b00, 32'h0BAD_0001};
        vecs[8]  = '{1'b0, 32'h80, 32'h0,         4'h0, 2'b10, 32'h0};
        vecs[9]  = '{1'b1, 32'h80, 32'hFFFF_FFFF, 4'hF, 2'b10, 32'h0};
        vecs[10] = '{1'b0, 32'h7C, 32'h0,         4'h0, 2'b00, 32'h5A00_000F};
        vecs[11] = '{1'b1, 32'h02, 32'h0000_00FF, 4'h1, 2'b00, 32'h0};
        vecs[12] = '{1'b0, 32'h01, 32'h0,         4'h0, 2'b00, 32'hA5A5_12FF};
        vecs[13] = '{1'b1, 32'h08, 32'hFFFF_FFFF, 4'h0, 2'b00, 32'h0};

        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        check("rst_awready", 64'(bus.awready), 64'd1);
        check("rst_wready",  64'(bus.wready),  64'd1);
        check("rst_arready", 64'(bus.arready), 64'd1);
        check("rst_bvalid",  64'(bus.bvalid),  64'd0);
        check("rst_rvalid",  64'(bus.rvalid),  64'd0);
        check("rst_bresp",   64'(bus.bresp),   64'd0);
        check("rst_rresp",   64'(bus.rresp),   64'd0);
        check("rst_rdata",   64'(bus.rdata),   64'd0);
        check("rst_rw_q",    64'(|rw_q),       64'd0);
        check("rst_wr_pulse", 64'(rw_wr_pulse), 64'd0);
        check("rst_rd_pulse", 64'(rd_pulse),   64'd0);

        for (int v = 0; v < 14; v++) begin
            if (vecs[v].is_wr) begin
                do_write(vecs[v].addr, vecs[v].data, vecs[v].strb, r);
                check($sformatf("vec%0d_bresp", v), 64'(r), 64'(vecs[v].resp));
                idx = int'(vecs[v].addr[31:2]);
                if (vecs[v].resp == 2'b00 && idx < 16) begin
                    for (int k = 0; k < 4; k++) begin
                        if (vecs[v].strb[k]) model[idx][8*k +: 8] = vecs[v].data[8*k +: 8];
                    end
                end
            end else begin
                do_read(vecs[v].addr, d, r);
                check($sformatf("vec%0d_rresp", v), 64'(r), 64'(vecs[v].resp));
                check($sformatf("vec%0d_rdata", v), 64'(d), 64'(vecs[v].rdata));
            end
        end
        do_read(32'h08, d, r);
        check("strb0_rdata", 64'(d), 64'd0);

        for (int i = 0; i < 16; i++) begin
            check($sformatf("model_rw%0d", i), 64'(rw_word(i)), 64'(model[i]));
        end

        // Write latency and pulse alignment with AW/W together.
        bus.awaddr = 32'h10; bus.wdata = 32'h42; bus.wstrb = 4'hF;
        bus.awvalid = 1; bus.wvalid = 1;
        tick();
        bus.awvalid = 0; bus.wvalid = 0;
        check("lat_bvalid_early", 64'(bus.bvalid), 64'd0);
        check("lat_pulse_early", 64'(rw_wr_pulse), 64'd0);
        tick();
        check("lat_bvalid", 64'(bus.bvalid), 64'd1);
        check("lat_bresp", 64'(bus.bresp), 64'd0);
        check("lat_rw4", 64'(rw_word(4)), 64'h42);
        check("lat_pulse", 64'(rw_wr_pulse), 64'h10);
        tick();
        check("lat_pulse_off", 64'(rw_wr_pulse), 64'd0);
        check("lat_bvalid_hold", 64'(bus.bvalid), 64'd1);
        check("lat_awready_busy", 64'(bus.awready), 64'd0);
        bus.bready = 1;
        tick();
        bus.bready = 0;
        check("lat_bvalid_clr", 64'(bus.bvalid), 64'd0);
        check("lat_awready_back", 64'(bus.awready), 64'd1);

        // W three cycles ahead of AW, partial strobe.
        bus.wdata = 32'hFFFF_FFFF; bus.wstrb = 4'b0101; bus.wvalid = 1;
        tick();
        bus.wvalid = 0;
        for (int c = 0; c < 3; c++) begin
            check("wfirst_wready", 64'(bus.wready), 64'd0);
            check("wfirst_awready", 64'(bus.awready), 64'd1);
            check("wfirst_bvalid", 64'(bus.bvalid), 64'd0);
            if (c < 2) tick();
        end
        bus.awaddr = 32'h04; bus.awvalid = 1;
        tick();
        bus.awvalid = 0;
        check("wfirst_no_commit", 64'(bus.bvalid), 64'd0);
        tick();
        check("wfirst_bvalid_set", 64'(bus.bvalid), 64'd1);
        check("wfirst_rw1", 64'(rw_word(1)), 64'h11FF_33FF);
        check("wfirst_pulse", 64'(rw_wr_pulse), 64'h2);
        bus.bready = 1;
        tick();
        bus.bready = 0;

        // Read with rready stalled; RO value sampled at acceptance.
        bus.araddr = 32'h44; bus.arvalid = 1;
        tick();
        bus.arvalid = 0;
        check("stall_rd_pulse", 64'(rd_pulse), 64'h0002_0000);
        ro_d[63:32] = 32'h0;
        for (int c = 0; c < 5; c++) begin
            check("stall_rvalid", 64'(bus.rvalid), 64'd1);
            check("stall_rdata", 64'(bus.rdata), 64'hCAFE_F00D);
            check("stall_arready", 64'(bus.arready), 64'd0);
            tick();
            if (c == 0) check("stall_rd_pulse_off", 64'(rd_pulse), 64'd0);
        end
        bus.rready = 1;
        tick();
        bus.rready = 0;
        check("stall_rvalid_clr", 64'(bus.rvalid), 64'd0);
        check("stall_arready_back", 64'(bus.arready), 64'd1);
        ro_d[63:32] = 32'hCAFE_F00D;

        // Read lands on the same edge as a write commit.
        do_write(32'h08, 32'h7, 4'hF, r);
        bus.awaddr = 32'h08; bus.wdata = 32'h9; bus.wstrb = 4'hF;
        bus.awvalid = 1; bus.wvalid = 1;
        tick();
        bus.awvalid = 0; bus.wvalid = 0;
        bus.araddr = 32'h08; bus.arvalid = 1;
        tick();
        bus.arvalid = 0;
        check("same_rvalid", 64'(bus.rvalid), 64'd1);
        check("same_rdata_old", 64'(bus.rdata), 64'h7);
        check("same_rw2_new", 64'(rw_word(2)), 64'h9);
        check("same_bvalid", 64'(bus.bvalid), 64'd1);
        bus.rready = 1; bus.bready = 1;
        tick();
        bus.rready = 0; bus.bready = 0;
        do_read(32'h08, d, r);
        check("same_rdata_new", 64'(d), 64'h9);

        // Reset with both responses pending.
        bus.awaddr = 32'h0C; bus.wdata = 32'h55; bus.wstrb = 4'hF;
        bus.awvalid = 1; bus.wvalid = 1;
        bus.araddr = 32'h00; bus.arvalid = 1;
        tick();
        bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0;
        tick();
        check("mid_pre_bvalid", 64'(bus.bvalid), 64'd1);
        check("mid_pre_rvalid", 64'(bus.rvalid), 64'd1);
        rst_n = 0;
        tick();
        check("mid_bvalid", 64'(bus.bvalid), 64'd0);
        check("mid_rvalid", 64'(bus.rvalid), 64'd0);
        check("mid_rw_q", 64'(|rw_q), 64'd0);
        rst_n = 1;
        tick();
        check("mid_awready", 64'(bus.awready), 64'd1);
        check("mid_wready", 64'(bus.wready), 64'd1);
        check("mid_arready", 64'(bus.arready), 64'd1);

        // A held AW must not survive reset.
        bus.awaddr = 32'h00; bus.awvalid = 1;
        tick();
        bus.awvalid = 0;
        rst_n = 0;
        tick();
        rst_n = 1;
        bus.wdata = 32'h77; bus.wstrb = 4'hF; bus.wvalid = 1;
        tick();
        bus.wvalid = 0;
        tick();
        tick();
        check("drop_no_commit", 64'(bus.bvalid), 64'd0);
        check("drop_rw0", 64'(rw_word(0)), 64'd0);
        bus.awaddr = 32'h00; bus.awvalid = 1;
        tick();
        bus.awvalid = 0;
        tick();
        check("drop_bvalid", 64'(bus.bvalid), 64'd1);
        check("drop_rw0_new", 64'(rw_word(0)), 64'h77);
        bus.bready = 1;
        tick();
        bus.bready = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi4_lite_reg_slave.md
# axi4_lite_reg_slave

AXI4-Lite responder terminating an `axi4_lite_if.slave` port in a bank of software-visible control/status registers. It is the slave end of the register path that CPU/PCIe-side AXI4-Lite masters drive, and it exposes register contents and write strobes to the surrounding datapath. It supports one outstanding write and one outstanding read, with independent AW and W acceptance.

## Interface
- `DATA_BYTE_WIDTH`, 4: bytes per data word; only 4 is supported.
- `ADDR_WIDTH`, 32: AXI address width.
- `NUM_RW`, 16: number of read/write registers, at word indices 0..NUM_RW-1.
- `NUM_RO`, 16: number of read-only registers, at word indices NUM_RW..NUM_RW+NUM_RO-1.

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `s_axil`  `axi4_lite_if.slave`  ADDR_WIDTH / 8*DATA_BYTE_WIDTH  register access port.
- `rw_q`  out  NUM_RW*32  flattened RW register contents; register i occupies bits [32i+31:32i].
- `rw_wr_pulse`  out  NUM_RW  one-cycle pulse on bit i when register i is written.
- `ro_d`  in  NUM_RO*32  read-only values; sampled on read acceptance.
- `rd_pulse`  out  NUM_RW+NUM_RO  one-cycle pulse on the bit of the register that was read with an OKAY response.

## Operation
- Word index is `addr[ADDR_WIDTH-1:2]`. `addr[1:0]` is ignored. `awprot` and `arprot` are ignored.
- **Write channel: AW and W are accepted independently.**
  - `awready = !aw_held && !bvalid`; `wready = !w_held && !bvalid`.
  - A handshake captures `awaddr`, or `wdata`/`wstrb`, into a holding register and sets the matching held flag.
- **Commit:** on the first edge where both `aw_held` and `w_held` are set:
  - If the index is in the RW range, each byte k of the register with `wstrb[k]=1` is updated; `rw_wr_pulse[i]=1` for one cycle, even when `wstrb=0`; `bresp=OKAY`.
  - If the index is in the RO range or out of range, no state changes and `bresp=SLVERR` (2'b10).
  - On the same edge: `bvalid` is set and both held flags clear.
- **B channel:** `bvalid` stays high until `bready`. It clears on the handshake edge; AW and W reopen on the following cycle.
- **Read channel:** `arready = !rvalid`.
  - On an AR handshake, `rdata`, `rresp` and `rvalid` are registered on the same edge.
  - RW index: returns the register value, OKAY. RO index: returns `ro_d` slice, OKAY. Out of range: returns 0, SLVERR.
  - `rvalid` stays high, with `rdata`/`rresp` stable, until `rready`.
- **Simultaneous read and write commit to the same register:** the read returns the pre-write value.

## Timing
- **Reset values:** `rw_q=0`, `rw_wr_pulse=0`, `rd_pulse=0`, `bvalid=0`, `rvalid=0`, `bresp=0`, `rresp=0`, `rdata=0`, held flags=0.
  - `awready`, `wready` and `arready` are 1 on the first cycle after reset.
- **Reset mid-transaction** drops any pending response, clears held data and restores the reset values above. No partial write is committed.
- **Write latency:** AW and W both accepted at edge N gives a register update plus `bvalid` at edge N+1.
  - If W arrives k cycles after AW, the commit happens one edge after the W handshake.
- **Read latency:** AR handshake at edge N gives `rvalid` at edge N; the data is visible in cycle N+1.
- **Pulses:** `rw_wr_pulse` is asserted in the cycle after the commit edge, aligned with the new `rw_q` value. `rd_pulse` is aligned with the `rvalid` rise.
- **Throughput:** back-to-back reads with `rready` held high reach 1 transaction per 2 cycles; writes likewise.
- **Protocol guarantees:**
  - No combinational path from any valid to any ready.
  - Outputs never depend on `bready` or `rready` within the same cycle.

## Structure
- Shared package `axi4_lite_pkg` holds:
  - response constants `RESP_OKAY=2'b00`, `RESP_EXOKAY=2'b01`, `RESP_SLVERR=2'b10`, `RESP_DECERR=2'b11`;
  - the typedef `axil_resp_t`;
  - the function `apply_wstrb(old, data, strb)`.
- Single module. The write FSM, with states `W_IDLE` / `W_PART` / `W_RESP`, and the read FSM, with states `R_IDLE` / `R_RESP`, stay inline; no sub-module is justified.

## Test plan
- Reset, then write 0xA5A5_1234 to 0x0 with `wstrb=4'hF` and AW/W in the same cycle → `bvalid` one cycle later with OKAY; `rw_q[31:0]=0xA5A5_1234`; `rw_wr_pulse[0]` high for 1 cycle.
- W presented 3 cycles before AW, `wstrb=4'b0101`, data 0xFFFF_FFFF, to 0x4 holding 0x1122_3344 → register reads 0x11FF_33FF; `wready` is low during the wait.
- Write to 0x40 (RO index 16) and read 0x80 (out of range) → `bresp=SLVERR` with no state change; `rresp=SLVERR` with `rdata=0`.
- Read 0x44 with `ro_d[63:32]=0xCAFE_F00D` and `rready` held low for 5 cycles → `rvalid` and `rdata` stable for all 5 cycles; `arready=0` until the handshake.
- Write commit and read of 0x8 on the same edge (old value 7, new value 9) → the read returns 7; a subsequent read returns 9.
- Deassert `rst_n` while `bvalid=1` and `rvalid=1` → both are 0 on the next cycle; all readies are 1 after reset is released; `rw_q` is 0.
